// File: rtl/gaussian_window_feeder.sv
// Builds 3x3 raster windows from a pixel stream using two line buffers and holds each
// window for HOLD_CYC clocks. Optional SOF resync checking: define GWF_SOF_CHECK_EN.
module gaussian_window_feeder #(
   parameter int DATA_W   = 27,
   parameter int IMG_W    = 64,
   parameter int IMG_H    = 64,
   parameter int HOLD_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sof,
   input  logic [DATA_W-1:0] in_data,
   output logic              start,
   output logic [DATA_W-1:0] Ix0,
   output logic [DATA_W-1:0] Ix1,
   output logic [DATA_W-1:0] Ix2,
   output logic [DATA_W-1:0] Ix3,
   output logic [DATA_W-1:0] Ix4,
   output logic [DATA_W-1:0] Ix5,
   output logic [DATA_W-1:0] Ix6,
   output logic [DATA_W-1:0] Ix7,
   output logic [DATA_W-1:0] Ix8,
`ifdef GWF_SOF_CHECK_EN
   output logic              err_resync,
`endif
   output logic              frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int HW = $clog2(HOLD_CYC + 1);

   // Handshake: a pixel transfers on a rising clk edge where in_valid && in_ready.
   typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [HW-1:0]     hold_cnt;
   logic              last_px;
   logic [DATA_W-1:0] win     [9];
   logic [DATA_W-1:0] nxt_win [9];
   logic [DATA_W-1:0] lb0     [IMG_W];
   logic [DATA_W-1:0] lb1     [IMG_W];
`ifdef GWF_SOF_CHECK_EN
   logic              expect_sof;
`endif

   logic          accept;
   logic          sof_restart;
   logic          take;
   logic          completes;
   logic          is_last;
   logic [CW-1:0] wr_col;

   assign accept = in_valid && in_ready;
`ifdef GWF_SOF_CHECK_EN
   assign sof_restart = accept && in_sof && (state == IDLE || state == RUN);
`else
   assign sof_restart = accept && in_sof && (state == IDLE);
`endif
   assign take      = sof_restart || (accept && state == RUN);
   assign wr_col    = sof_restart ? '0 : col;
   assign completes = accept && (state == RUN) && !sof_restart &&
                      (row >= RW'(2)) && (col >= CW'(2));
   assign is_last   = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

   // Window shifts left; the new right column comes from two rows up, one row up, and now.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         nxt_win[3*i]   = win[3*i+1];
         nxt_win[3*i+1] = win[3*i+2];
      end
      nxt_win[2] = lb1[wr_col];
      nxt_win[5] = lb0[wr_col];
      nxt_win[8] = in_data;
   end

   always_ff @(posedge clk) begin
      if (take) begin
         lb1[wr_col] <= lb0[wr_col];
         lb0[wr_col] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         hold_cnt   <= '0;
         last_px    <= 1'b0;
         for (int i = 0; i < 9; i++) win[i] <= '0;
         start      <= 1'b0;
         {Ix0, Ix1, Ix2, Ix3, Ix4, Ix5, Ix6, Ix7, Ix8} <= '0;
         frame_done <= 1'b0;
         in_ready   <= 1'b0;
`ifdef GWF_SOF_CHECK_EN
         err_resync <= 1'b0;
         expect_sof <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (take) begin
            for (int i = 0; i < 9; i++) win[i] <= nxt_win[i];
         end
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (sof_restart) begin
                  state <= RUN;
                  col   <= CW'(1);
                  row   <= '0;
`ifdef GWF_SOF_CHECK_EN
                  expect_sof <= 1'b0;
               end else if (accept) begin
                  if (expect_sof) err_resync <= 1'b1;
                  expect_sof <= 1'b0;
`endif
               end
            end
            RUN: begin
               in_ready <= 1'b1;
               if (sof_restart) begin
                  col <= CW'(1);
                  row <= '0;
`ifdef GWF_SOF_CHECK_EN
                  err_resync <= 1'b1;
`endif
               end else if (accept) begin
                  if (col == CW'(IMG_W - 1)) begin
                     col <= '0;
                     row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
                  end else begin
                     col <= col + CW'(1);
                  end
                  if (completes) begin
                     state    <= HOLD;
                     in_ready <= 1'b0;
                     start    <= 1'b1;
                     hold_cnt <= '0;
                     last_px  <= is_last;
                     {Ix0, Ix1, Ix2, Ix3, Ix4, Ix5, Ix6, Ix7, Ix8} <=
                        {nxt_win[0], nxt_win[1], nxt_win[2], nxt_win[3], nxt_win[4],
                         nxt_win[5], nxt_win[6], nxt_win[7], nxt_win[8]};
                  end
               end
            end
            HOLD: begin
               if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                  start <= 1'b0;
                  if (last_px) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end else begin
                     state    <= RUN;
                     in_ready <= 1'b1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            DONE: begin
               state    <= IDLE;
               in_ready <= 1'b1;
`ifdef GWF_SOF_CHECK_EN
               expect_sof <= 1'b1;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
